// File: rtl/apb_alarm_pkg.sv
// Shared types for the APB command master: FSM state encoding, timeout counter
// width, alarm-block register offsets and an alignment helper.
package apb_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Wide enough for the largest legal TIMEOUT_CYCLES (255).
    localparam int unsigned TMO_CNT_W = 8;

    localparam logic [31:0] TIME_INIT  = 32'h0000_0000;
    localparam logic [31:0] TIME_ALARM = 32'h0000_0004;
    localparam logic [31:0] TIME_NOW   = 32'h0000_0008;
    localparam logic [31:0] ALARM_OFF  = 32'h0000_000C;

    function automatic logic addr_aligned(input logic [1:0] low_bits);
        return (low_bits == 2'b00);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting on the completer and flags the cycle
// that would be the LIMIT-th consecutive wait.
module apb_timeout_cnt
    import apb_alarm_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  logic pclk_i,
    input  logic presetn_i,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [TMO_CNT_W-1:0] cnt_q;
    logic [TMO_CNT_W-1:0] cnt_d;

    // hit_o is qualified by en_i so a completing cycle (pready high) never aborts.
    assign hit_o = en_i && (cnt_q == TMO_CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_cmd_master.sv
// Turns single read/write commands into APB transfers and returns one
// response per command; every APB and response output comes from a flop.
module apb_cmd_master
    import apb_alarm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        pclk_i,
    input  logic        presetn_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_strb_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic [31:0] prdata_i,
    input  logic        pslverr_i
);

    // Handshakes: a command moves when cmd_valid_i && cmd_ready_o at a rising
    // edge; a response moves when rsp_valid_o && rsp_ready_i. Valid never
    // depends on ready, and payload is held stable while valid is high.

    state_e state_q, state_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic accept;
    logic misaligned;
    logic tmo_clr;
    logic tmo_en;
    logic tmo_hit;

    assign accept     = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid_i;
    assign misaligned = !addr_aligned(cmd_addr_i[1:0]);
    assign tmo_clr    = accept && !misaligned;
    assign tmo_en     = (state_q == ST_ACCESS) && !pready_i;

    apb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .pclk_i    (pclk_i),
        .presetn_i (presetn_i),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .hit_o     (tmo_hit)
    );

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = misaligned ? ST_RESP : ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready_i || tmo_hit) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so the registered copies line
    // up with the state they belong to.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        rsp_valid_d = (state_d == ST_RESP);

        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        if (accept && !misaligned) begin
            paddr_d  = cmd_addr_i;
            pwrite_d = cmd_write_i;
            pwdata_d = cmd_write_i ? cmd_wdata_i : 32'h0;
            pstrb_d  = cmd_write_i ? cmd_strb_i : 4'h0;
        end
        if (!psel_d) begin
            pwrite_d = 1'b0;
        end

        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        if (accept && misaligned) begin
            rsp_rdata_d   = 32'h0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
        end else if ((state_q == ST_ACCESS) && pready_i) begin
            // Read data only survives a clean read; writes and errors return zero.
            rsp_rdata_d   = (!pwrite_q && !pslverr_i) ? prdata_i : 32'h0;
            rsp_err_d     = pslverr_i;
            rsp_timeout_d = 1'b0;
        end else if ((state_q == ST_ACCESS) && tmo_hit) begin
            rsp_rdata_d   = 32'h0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
        end else if (state_d == ST_IDLE) begin
            rsp_rdata_d   = 32'h0;
            rsp_err_d     = 1'b0;
            rsp_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 32'h0;
            pwdata_q      <= 32'h0;
            pstrb_q       <= 4'h0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed corner cases followed by
// random commands against a transaction-level model of the response.
module tb_apb_cmd_master;
    import apb_alarm_pkg::*;

    localparam int TMO = 16;

    logic        pclk_i = 1'b0;
    logic        presetn_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [31:0] pwdata_o;
    logic [3:0]  pstrb_o;
    logic        pready_i;
    logic [31:0] prdata_i;
    logic        pslverr_i;

    apb_cmd_master #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk_i        (pclk_i),
        .presetn_i     (presetn_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_write_i   (cmd_write_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_strb_i    (cmd_strb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .psel_o        (psel_o),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .paddr_o       (paddr_o),
        .pwdata_o      (pwdata_o),
        .pstrb_o       (pstrb_o),
        .pready_i      (pready_i),
        .prdata_i      (prdata_i),
        .pslverr_i     (pslverr_i)
    );

    // Clock and cycle counter
    always #5 pclk_i = ~pclk_i;

    int cyc = 0;
    always @(posedge pclk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard entries: {err, timeout, rdata}
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    // Issue one command, play the APB completer, then drain the response.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input logic slverr,
                           input logic [31:0] rdata, input int hold);
        logic        mis;
        logic [33:0] exp;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
        int          acc_exp;
        int          lat_exp;
        int          setup_n;
        int          acc_n;
        int          t0;
        int          guard;
        bit          got_rsp;

        guard = 0;
        while (!cmd_ready_o && guard < 20) begin
            tick();
            guard++;
        end
        check("cmd_ready_wait", 64'(cmd_ready_o), 64'(1));

        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        cmd_strb_i  = strb;
        tick();
        t0          = cyc;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom_range(0, 1));
        cmd_addr_i  = $urandom;
        cmd_wdata_i = $urandom;
        cmd_strb_i  = 4'($urandom);

        // Transaction-level model of what the master must produce.
        mis = (addr[1:0] != 2'b00);
        if (mis) begin
            exp     = {1'b1, 1'b0, 32'h0};
            acc_exp = 0;
            lat_exp = 1 + hold;
        end else if (waits >= TMO) begin
            exp     = {1'b1, 1'b1, 32'h0};
            acc_exp = TMO;
            lat_exp = 2 + acc_exp + hold;
        end else begin
            exp     = {slverr, 1'b0, (wr || slverr) ? 32'h0 : rdata};
            acc_exp = waits + 1;
            lat_exp = 2 + acc_exp + hold;
        end
        exp_q.push_back(exp);
        exp_pwdata = wr ? wdata : 32'h0;
        exp_pstrb  = wr ? strb : 4'h0;

        setup_n = 0;
        acc_n   = 0;
        got_rsp = 0;
        for (int i = 0; i < 300 && !got_rsp; i++) begin
            pready_i  = 1'b0;
            pslverr_i = 1'($urandom_range(0, 1));
            prdata_i  = $urandom;
            if (rsp_valid_o) begin
                got_rsp = 1;
            end else begin
                if (psel_o) begin
                    check("paddr", 64'(paddr_o), 64'(addr));
                    check("pwrite", 64'(pwrite_o), 64'(wr));
                    check("pwdata", 64'(pwdata_o), 64'(exp_pwdata));
                    check("pstrb", 64'(pstrb_o), 64'(exp_pstrb));
                    if (!penable_o) begin
                        check("setup_before_access", 64'(acc_n), 64'(0));
                        setup_n++;
                    end else begin
                        acc_n++;
                        if (acc_n == waits + 1) begin
                            pready_i  = 1'b1;
                            pslverr_i = slverr;
                            prdata_i  = rdata;
                        end
                    end
                end else begin
                    check("idle_ctrl", 64'({penable_o, pwrite_o}), 64'(0));
                end
                tick();
            end
        end
        pready_i  = 1'b0;
        pslverr_i = 1'b0;

        check("rsp_seen", 64'(got_rsp), 64'(1));
        exp = exp_q.pop_front();
        if (!got_rsp) return;
        check("setup_cycles", 64'(setup_n), 64'(mis ? 0 : 1));
        check("access_cycles", 64'(acc_n), 64'(acc_exp));
        check("ctrl_in_resp", 64'({psel_o, penable_o, pwrite_o}), 64'(0));

        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid", 64'(rsp_valid_o), 64'(1));
            check("rsp_fields", 64'({rsp_err_o, rsp_timeout_o, rsp_rdata_o}), 64'(exp));
            check("cmd_ready_in_resp", 64'(cmd_ready_o), 64'(0));
            if (h == hold) rsp_ready_i = 1'b1;
            tick();
        end
        rsp_ready_i = 1'b0;
        check("rsp_drop", 64'(rsp_valid_o), 64'(0));
        check("cmd_ready_back", 64'(cmd_ready_o), 64'(1));
        check("latency", 64'(cyc - t0), 64'(lat_exp));
    endtask

    initial begin
        int waits;
        int pick;
        logic [31:0] addr;

        presetn_i   = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = 32'h0;
        cmd_wdata_i = 32'h0;
        cmd_strb_i  = 4'h0;
        rsp_ready_i = 1'b0;
        pready_i    = 1'b0;
        prdata_i    = 32'h0;
        pslverr_i   = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_outputs", 64'({cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o,
                                    psel_o, penable_o, pwrite_o, pstrb_o}), 64'(0));
        check("reset_paddr", 64'(paddr_o), 64'(0));
        check("reset_rdata", 64'(rsp_rdata_o), 64'(0));
        @(negedge pclk_i);
        presetn_i = 1'b1;
        #1;
        check("cmd_ready_before_clk", 64'(cmd_ready_o), 64'(0));
        tick();
        check("cmd_ready_after_clk", 64'(cmd_ready_o), 64'(1));

        // Directed corners
        run_txn(1'b1, TIME_ALARM, 32'h0001_0730, 4'hF, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, TIME_NOW, 32'h0, 4'h0, 3, 1'b0, 32'h0000_1245, 0);
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF, 0);
        run_txn(1'b0, TIME_INIT, 32'h0, 4'h0, TMO, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b0, ALARM_OFF, 32'h0, 4'h0, TMO - 1, 1'b0, 32'hCAFE_0001, 0);
        run_txn(1'b1, 32'h0000_0006, 32'h5555_AAAA, 4'h3, 0, 1'b0, 32'h0, 0);
        run_txn(1'b0, TIME_NOW, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 5);

        // Random commands
        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 9);
            if (pick < 6)       waits = $urandom_range(0, 5);
            else if (pick == 6) waits = TMO - 1;
            else if (pick == 7) waits = TMO;
            else                waits = $urandom_range(0, 2);
            addr = $urandom;
            if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
            run_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), waits,
                    1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
        end

        // Reset in the middle of an ACCESS phase
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_addr_i  = TIME_NOW;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        check("mid_access", 64'({psel_o, penable_o}), 64'(3));
        #3;
        presetn_i = 1'b0;
        #1;
        check("abort_ctrl", 64'({psel_o, penable_o, pwrite_o}), 64'(0));
        check("abort_rsp", 64'({rsp_valid_o, cmd_ready_o}), 64'(0));
        @(negedge pclk_i);
        presetn_i = 1'b1;
        tick();
        check("cmd_ready_after_abort", 64'(cmd_ready_o), 64'(1));
        for (int k = 0; k < 8; k++) begin
            check("no_rsp_after_abort", 64'({rsp_valid_o, psel_o}), 64'(0));
            tick();
        end

        // Master still works after the abort
        run_txn(1'b0, TIME_ALARM, 32'h0, 4'h0, 2, 1'b0, 32'h0000_0730, 1);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, ACCESS-phase cycles without pready_i before abort (legal 2..255).
REQ-002 SHALL have port pclk_i  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port presetn_i  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cmd_valid_i  input  1  command request.
REQ-005 SHALL have port cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-006 SHALL have port cmd_write_i  input  1  1=write, 0=read.
REQ-007 SHALL have port cmd_addr_i  input  32  byte address.
REQ-008 SHALL have port cmd_wdata_i  input  32  write data.
REQ-009 SHALL have port cmd_strb_i  input  4  write byte strobes.
REQ-010 SHALL have port rsp_valid_o  output  1  response available.
REQ-011 SHALL have port rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-012 SHALL have port rsp_rdata_o  output  32  read data (0 for writes and errors).
REQ-013 SHALL have port rsp_err_o  output  1  slave error, misalignment or timeout.
REQ-014 SHALL have port rsp_timeout_o  output  1  error was a timeout.
REQ-015 SHALL have ports psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-016 SHALL have ports paddr_o  output  32, pwdata_o  output  32, pstrb_o  output  4  APB address/data/strobes.
REQ-017 SHALL have ports pready_i  input  1, prdata_i  input  32, pslverr_i  input  1  APB completer response.

Function
REQ-018 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; all APB and rsp outputs registered.
REQ-019 cmd_ready_o SHALL be 1 only in IDLE; handshake at edge N captures the command and enters SETUP at N+1.
REQ-020 Misaligned command (cmd_addr_i[1:0]!=0) SHALL go IDLE->RESP directly, no psel_o, rsp_err_o=1, rsp_timeout_o=0.
REQ-021 SETUP: psel_o=1, penable_o=0, exactly one cycle, then ACCESS.
REQ-022 ACCESS: psel_o=1, penable_o=1, held until pready_i=1 or timeout.
REQ-023 paddr_o, pwrite_o, pwdata_o, pstrb_o SHALL stay constant from SETUP through final ACCESS cycle.
REQ-024 Reads SHALL drive pstrb_o=0 and pwdata_o=0.
REQ-025 On ACCESS with pready_i=1: capture prdata_i (reads only) and pslverr_i into rsp, enter RESP next cycle, drop psel_o/penable_o.
REQ-026 pslverr_i and prdata_i SHALL be ignored when pready_i=0.
REQ-027 Timeout counter SHALL clear on SETUP entry, increment each ACCESS cycle with pready_i=0; at TIMEOUT_CYCLES abort: drop psel_o/penable_o, RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-028 pready_i=1 on the same cycle as counter reaching limit SHALL count as normal completion.
REQ-029 RESP: rsp_valid_o=1 with stable rsp fields until rsp_ready_i=1; then IDLE next cycle; no command accepted in RESP.
REQ-030 Minimum command-to-command period SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP) with zero-wait slave and rsp_ready_i=1.
REQ-031 Outside SETUP/ACCESS, psel_o, penable_o, pwrite_o SHALL be 0.

Reset
REQ-032 presetn_i low SHALL asynchronously force IDLE and all outputs to 0 except cmd_ready_o, which SHALL be 0 during reset and 1 from the first clock after deassertion.
REQ-033 Reset mid-ACCESS SHALL abandon the transfer without producing a response.

Structure
REQ-034 Package apb_alarm_pkg SHALL hold the FSM state enum and register offsets TIME_INIT=0x0, TIME_ALARM=0x4, TIME_NOW=0x8, ALARM_OFF=0xC.
REQ-035 Timeout counter SHALL be sub-module apb_timeout_cnt (clear, enable, limit-reached output).

Verification
REQ-036 Write 0x4 data 0x0001_0730 strb 0xF, pready one cycle after psel -> one SETUP, one ACCESS, rsp_err_o=0, rsp_rdata_o=0.
REQ-037 Read 0x8, slave returns 0x0000_1245 after 3 wait cycles -> signals stable across waits, rsp_rdata_o=0x0000_1245.
REQ-038 Read 0x10, slave pslverr_i=1 with pready_i -> rsp_err_o=1, rsp_timeout_o=0.
REQ-039 pready_i held 0 -> abort after 16 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1; misaligned 0x6 -> no psel_o, rsp_err_o=1.
REQ-040 rsp_ready_i low 5 cycles -> rsp fields stable, cmd_ready_o=0; reset asserted mid-ACCESS -> psel_o=0 immediately, no rsp_valid_o afterward.
